// File: rtl/bin_invert_stream.sv
// Streaming 1-bit pixel inverter with valid/ready flow control, raster
// position tagging (sol/eol/sof/eof) and a two-entry skid buffer so that
// s_ready is driven straight from a flop.
module bin_invert_stream #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned CW         = $clog2(IMG_WIDTH),
   parameter int unsigned RW         = $clog2(IMG_HEIGHT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic invert_en,
   input  logic s_valid,
   output logic s_ready,
   input  logic s_data,
   output logic m_valid,
   input  logic m_ready,
   output logic m_data,
   output logic m_sol,
   output logic m_eol,
   output logic m_sof,
   output logic m_eof,
   output logic frame_done
);

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   typedef struct packed {
      logic data;
      logic sol;
      logic eol;
      logic sof;
      logic eof;
   } tag_t;

   state_e        state_q, state_d;
   tag_t          out_q, out_d;
   tag_t          skd_q, skd_d;
   tag_t          in_tag;
   logic [CW-1:0] x_q, x_d;
   logic [RW-1:0] y_q, y_d;
   logic          s_ready_q;
   logic          frame_done_q;
   logic          acc;
   logic          xfer;
   logic          x_last;
   logic          y_last;

   assign acc    = s_valid & s_ready_q;
   assign xfer   = m_valid & m_ready;
   assign x_last = (x_q == CW'(IMG_WIDTH - 1));
   assign y_last = (y_q == RW'(IMG_HEIGHT - 1));

   // Tag the incoming pixel from the raster position it will occupy.
   always_comb begin
      in_tag      = '0;
      in_tag.data = s_data ^ invert_en;
      in_tag.sol  = (x_q == '0);
      in_tag.eol  = x_last;
      in_tag.sof  = (x_q == '0) && (y_q == '0);
      in_tag.eof  = x_last && y_last;
   end

   // Raster counters advance only on accepted pixels.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (acc) begin
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + RW'(1);
         end else begin
            x_d = x_q + CW'(1);
         end
      end
   end

   // Skid-buffer occupancy control: OUT is the presented beat, SKD catches
   // the one beat that can arrive while OUT is stalled.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skd_d   = skd_q;
      case (state_q)
         StEmpty: begin
            if (acc) begin
               out_d   = in_tag;
               state_d = StOne;
            end
         end
         StOne: begin
            if (acc && xfer) begin
               out_d = in_tag;
            end else if (acc) begin
               skd_d   = in_tag;
               state_d = StTwo;
            end else if (xfer) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            // s_ready is low here, so only a drain is possible.
            if (xfer) begin
               out_d   = skd_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   // State, storage, counters and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StEmpty;
         out_q        <= '0;
         skd_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         s_ready_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_q        <= out_d;
         skd_q        <= skd_d;
         x_q          <= x_d;
         y_q          <= y_d;
         s_ready_q    <= (state_d != StTwo);
         frame_done_q <= xfer & out_q.eof;
      end
   end

   assign s_ready    = s_ready_q;
   assign m_valid    = (state_q != StEmpty);
   assign m_data     = out_q.data;
   assign m_sol      = out_q.sol;
   assign m_eol      = out_q.eol;
   assign m_sof      = out_q.sof;
   assign m_eof      = out_q.eof;
   assign frame_done = frame_done_q;

endmodule

// File: doc/bin_invert_stream.md
# bin_invert_stream

Streaming 1-bit binary-image inverter with full valid/ready flow control and raster position tagging. It sits between a binarization/threshold stage and downstream morphology or writer stages. It accepts one 1-bit pixel per cycle, optionally inverts it, and outputs the pixel with start/end-of-line and start/end-of-frame markers derived from internal x/y counters. A two-entry skid buffer keeps `s_ready` registered and preserves full throughput under back-pressure.

## Interface
- `IMG_WIDTH`, 640: pixels per line; must be ≥ 2.
- `IMG_HEIGHT`, 480: lines per frame; must be ≥ 2.
- `CW`, $clog2(IMG_WIDTH), x counter width.
- `RW`, $clog2(IMG_HEIGHT), y counter width.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `invert_en`  in  1  1 = output is ~pixel, 0 = pass through; sampled at input acceptance.
- `s_valid`  in  1  input pixel valid.
- `s_ready`  out  1  input ready; registered.
- `s_data`  in  1  input pixel.
- `m_valid`  out  1  output pixel valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  1  output pixel.
- `m_sol` / `m_eol`  out  1  first / last pixel of a line; qualified by `m_valid`.
- `m_sof` / `m_eof`  out  1  first / last pixel of a frame; qualified by `m_valid`.
- `frame_done`  out  1  one-cycle pulse when the `m_eof` beat transfers.

## Operation
- Accept: `acc = s_valid & s_ready`. Transfer: `xfer = m_valid & m_ready`.
- Tagging at accept, using counters x (CW bits) and y (RW bits):
  - data = s_data ^ invert_en
  - sol = (x==0); eol = (x==IMG_WIDTH-1)
  - sof = (x==0 & y==0); eof = (eol & y==IMG_HEIGHT-1)
- Counter advance on `acc`:
  - x wraps to 0 after IMG_WIDTH-1; y increments on x wrap.
  - y wraps to 0 after IMG_HEIGHT-1.
  - Counters never move without `acc`.
- Storage: output register OUT (5-bit tag + valid) and skid register SKD (5-bit tag + full).
- State machine, 3 states:
  - EMPTY: OUT invalid, SKD empty.
  - ONE: OUT valid, SKD empty.
  - TWO: OUT valid, SKD full.
- Transitions:
  - EMPTY: acc → ONE (beat loads OUT).
  - ONE, acc & xfer: new beat loads OUT, stay ONE.
  - ONE, acc & !xfer: new beat loads SKD → TWO.
  - ONE, !acc & xfer → EMPTY.
  - ONE, neither: stay ONE.
  - TWO, xfer: SKD moves to OUT → ONE. No acc is possible in TWO.
- `s_ready` = registered (next state != TWO).
- `m_valid` = (state != EMPTY). `m_*` outputs are driven straight from OUT.
- OUT and SKD hold steady while `m_valid & !m_ready`.
- `invert_en` changes take effect only for pixels accepted after the change. Buffered pixels are not re-evaluated.
- `frame_done` = registered (xfer & OUT.eof).

## Timing
- Reset values (asynchronous, `rst_n`=0):
  - state EMPTY, x=0, y=0.
  - `m_valid`=0, `m_data`=0, `m_sol`=`m_eol`=`m_sof`=`m_eof`=0.
  - `s_ready`=0 while in reset; `s_ready`=1 from the first clock edge after release.
  - `frame_done`=0.
- Latency: a pixel accepted at edge N is presented with `m_valid`=1 after edge N (1 cycle) when the buffer was empty.
- Throughput: 1 pixel/cycle with `m_ready` held high.
- Under continuous back-pressure, at most 2 beats are accepted before `s_ready` drops. `s_ready` reasserts the cycle after the first transfer.
- Simultaneous accept and transfer in ONE: no bubble, no loss, no duplication.
- Reset mid-frame: buffered pixels are discarded, counters return to 0, and the next accepted pixel carries `sof`.
- `m_valid` must never deassert without a transfer. Output tag bits must be stable while stalled.

## Test plan
Use IMG_WIDTH=4 and IMG_HEIGHT=2 unless noted.
- **Pass-through:** `invert_en`=0, `m_ready`=1, 8 pixels 1,0,1,1,0,0,1,0 → same pattern out, 1 cycle later. `sol` on beats 0 and 4, `eol` on beats 3 and 7, `sof` on beat 0, `eof` on beat 7, one `frame_done` pulse.
- **Invert:** `invert_en`=1, same stream → 0,1,0,0,1,1,0,1. Markers identical to pass-through.
- **Back-pressure:** `m_ready`=0 with `s_valid`=1 → exactly 2 beats accepted, `s_ready`=0 on the following cycle. Release `m_ready` → beats emerge in order with no gap, and `s_ready`=1 one cycle after the first transfer.
- **Random stalls:** 3 frames of random data with random `s_valid`/`m_ready` (50%) → output equals scoreboard data ^ `invert_en` per beat, and markers sit at positions mod 4 / mod 8.
- **Toggle inversion:** `invert_en` toggles while 2 beats are buffered and stalled → buffered beats keep their original polarity, and new beats use the new value.
- **Mid-frame reset:** assert `rst_n`=0 after 5 accepted pixels → `m_valid`=0 immediately. After release, the first beat has `sof`=1 and `sol`=1.
